// File: rtl/serializador_pkg.sv
// Shared types and constants for the FIFO-to-UART serializer.
// Frame length helper gives total cycles per frame for a parameter set.
package serializador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEER,
        CARGAR,
        START,
        DATOS,
        PARIDAD,
        STOP
    } estado_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int longitud_trama(input int clk_div, input int paridad, input int stop_bits);
        return (9 + ((paridad != PAR_NONE) ? 1 : 0) + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/serializador_uart_baudios.sv
// Bit-time generator: counts 0..CLK_DIV-1 and ticks fin_bit on the last count.
// The owner clears it whenever the serializer changes state so every bit starts aligned.
module generador_baudios #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic limpiar,
    output logic fin_bit
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] CUENTA_MAX = W'(CLK_DIV - 1);

    logic [W-1:0] cuenta_reg;
    logic [W-1:0] cuenta_next;

    assign fin_bit = (cuenta_reg == CUENTA_MAX);

    always_comb begin
        cuenta_next = cuenta_reg + 1'b1;
        if (limpiar || fin_bit) begin
            cuenta_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cuenta_reg <= '0;
        end else begin
            cuenta_reg <= cuenta_next;
        end
    end

endmodule

// File: rtl/serializador_uart.sv
// Drains an 8-bit FIFO and sends each byte as an asynchronous serial frame on tx.
// All outputs are registered from the next state so they align with state entry.
module serializador_uart
    import serializador_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        vacio,
    input  logic [7:0]  data_out,
    output logic        rd_en,
    output logic        tx,
    output logic        ocupado,
    output logic [15:0] tramas
);

    localparam logic [1:0] STOP_ULT    = 2'(STOP_BITS - 1);
    localparam logic       PAR_INV     = (PARITY == PAR_ODD);
    localparam logic       CON_PARIDAD = (PARITY != PAR_NONE);

    estado_t     estado_reg, estado_next;
    logic [7:0]  shift_reg, shift_next;
    logic        paridad_reg, paridad_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [1:0]  stop_cnt_reg, stop_cnt_next;
    logic [15:0] tramas_reg, tramas_next;
    logic        tx_reg, tx_next;
    logic        rd_en_reg, rd_en_next;
    logic        ocupado_reg, ocupado_next;
    logic        fin_bit;
    logic        limpiar;

    assign limpiar = (estado_next != estado_reg);

    generador_baudios #(.CLK_DIV(CLK_DIV)) u_baudios (
        .clk     (clk),
        .rst     (rst),
        .limpiar (limpiar),
        .fin_bit (fin_bit)
    );

    always_comb begin
        estado_next   = estado_reg;
        shift_next    = shift_reg;
        paridad_next  = paridad_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        tramas_next   = tramas_reg;
        tx_next       = 1'b1;

        case (estado_reg)
            IDLE:    if (tx_en && !vacio) estado_next = LEER;
            LEER:    estado_next = CARGAR;
            CARGAR: begin
                shift_next    = data_out;
                paridad_next  = (^data_out) ^ PAR_INV;
                bit_cnt_next  = '0;
                stop_cnt_next = '0;
                estado_next   = START;
            end
            START:   if (fin_bit) estado_next = DATOS;
            DATOS: begin
                if (fin_bit) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        estado_next = CON_PARIDAD ? PARIDAD : STOP;
                    end
                end
            end
            PARIDAD: if (fin_bit) estado_next = STOP;
            STOP: begin
                if (fin_bit) begin
                    if (stop_cnt_reg == STOP_ULT) begin
                        estado_next = IDLE;
                        tramas_next = tramas_reg + 16'd1;
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 2'd1;
                    end
                end
            end
            default: estado_next = IDLE;
        endcase

        // Line level for the cycle we are about to enter
        case (estado_next)
            START:   tx_next = 1'b0;
            DATOS:   tx_next = shift_next[0];
            PARIDAD: tx_next = paridad_reg;
            default: tx_next = 1'b1;
        endcase
        rd_en_next   = (estado_next == LEER);
        ocupado_next = (estado_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_reg   <= IDLE;
            shift_reg    <= '0;
            paridad_reg  <= 1'b0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            tramas_reg   <= '0;
            tx_reg       <= 1'b1;
            rd_en_reg    <= 1'b0;
            ocupado_reg  <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            shift_reg    <= shift_next;
            paridad_reg  <= paridad_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            tramas_reg   <= tramas_next;
            tx_reg       <= tx_next;
            rd_en_reg    <= rd_en_next;
            ocupado_reg  <= ocupado_next;
        end
    end

    assign tx      = tx_reg;
    assign rd_en   = rd_en_reg;
    assign ocupado = ocupado_reg;
    assign tramas  = tramas_reg;

endmodule

// File: tb/tb_serializador_uart.sv
// Randomized bench for serializador_uart: four parameter sets, a queue-based FIFO model
// and a frame-level reference that rebuilds the expected tx waveform from each byte read.
module tb_serializador_uart;

    localparam int N_DUT = 4;
    localparam int DIVS  [N_DUT] = '{16, 16, 16, 4};
    localparam int PARS  [N_DUT] = '{0, 1, 2, 0};
    localparam int STOPS [N_DUT] = '{1, 1, 1, 2};
    localparam int LOG_N = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [N_DUT-1:0]       tx_en;
    logic [N_DUT-1:0]       vacio;
    logic [N_DUT-1:0][7:0]  data_out;
    logic [N_DUT-1:0]       rd_en;
    logic [N_DUT-1:0]       tx;
    logic [N_DUT-1:0]       ocupado;
    logic [N_DUT-1:0][15:0] tramas;

    generate
        for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
            serializador_uart #(
                .CLK_DIV   (DIVS[gi]),
                .PARITY    (PARS[gi]),
                .STOP_BITS (STOPS[gi])
            ) dut (
                .clk      (clk),
                .rst      (rst),
                .tx_en    (tx_en[gi]),
                .vacio    (vacio[gi]),
                .data_out (data_out[gi]),
                .rd_en    (rd_en[gi]),
                .tx       (tx[gi]),
                .ocupado  (ocupado[gi]),
                .tramas   (tramas[gi])
            );
        end
    endgenerate

    int n_comp   = 0;
    int n_fallos = 0;
    int cyc      = 0;
    int act      = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] leidos [$];
    int         rd_q   [$];
    logic       tx_log [LOG_N];
    logic       oc_log [LOG_N];

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_fallos++;
            $display("FAIL %s: observado=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // One clock step: FIFO model answers rd_en, then the active DUT's lines are logged.
    task automatic paso();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_en[act]) begin
            if (fifo_q.size() > 0) data_out[act] = fifo_q.pop_front();
            leidos.push_back(data_out[act]);
            rd_q.push_back(cyc);
            vacio[act] = (fifo_q.size() == 0);
        end
        if (cyc < LOG_N) begin
            tx_log[cyc] = tx[act];
            oc_log[cyc] = ocupado[act];
        end
    endtask

    task automatic reinicio(input int k);
        rst   = 1'b0;
        tx_en = '0;
        vacio = '1;
        act   = k;
        repeat (3) paso();
        for (int d = 0; d < N_DUT; d++) begin
            comprobar("rst_tx", 32'(tx[d]), 32'd1);
            comprobar("rst_rd_en", 32'(rd_en[d]), 32'd0);
            comprobar("rst_ocupado", 32'(ocupado[d]), 32'd0);
            comprobar("rst_tramas", 32'(tramas[d]), 32'd0);
        end
        rst = 1'b1;
        fifo_q.delete();
        leidos.delete();
        rd_q.delete();
        cyc = 0;
    endtask

    task automatic esperar_rd(input int previos, input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            paso();
            if (rd_q.size() > previos) ok = 1'b1;
        end
        if (!ok) comprobar("timeout_rd", 32'd0, 32'd1);
    endtask

    // Expected frame: start 0, data LSB first, optional parity, stop ones.
    task automatic verificar(input int k, input int n_esp, input bit continuo);
        int   d;
        int   nbits;
        int   f;
        int   r;
        int   idx;
        logic [7:0] b;
        logic e;
        logic got;
        d     = DIVS[k];
        nbits = 9 + ((PARS[k] != 0) ? 1 : 0) + STOPS[k];
        f     = nbits * d;
        comprobar("n_rd", 32'(rd_q.size()), 32'(n_esp));
        for (int i = 0; i < rd_q.size() && i < leidos.size(); i++) begin
            r = rd_q[i];
            b = leidos[i];
            $display("trama dut%0d byte=%02h rd_en@%0d tramas=%0d", k, b, r, tramas[k]);
            if (continuo && i > 0) comprobar("periodo_rd", 32'(r - rd_q[i-1]), 32'(f + 3));
            comprobar("ocupado_ini", 32'(oc_log[r]), 32'd1);
            comprobar("tx_previo", 32'({tx_log[r], tx_log[r+1]}), 32'd3);
            for (int j = 0; j < nbits; j++) begin
                if (j == 0)                         e = 1'b0;
                else if (j <= 8)                    e = b[j-1];
                else if (j == 9 && PARS[k] != 0)    e = (^b) ^ (PARS[k] == 2);
                else                                e = 1'b1;
                got = e;
                for (int c = 0; c < d; c++) begin
                    idx = r + 2 + j * d + c;
                    if (idx < LOG_N && tx_log[idx] !== e) got = tx_log[idx];
                end
                comprobar($sformatf("dut%0d_bit%0d", k, j), 32'(got), 32'(e));
            end
            if (r + 2 + f < LOG_N) begin
                comprobar("ocupado_fin", 32'(oc_log[r+1+f]), 32'd1);
                comprobar("ocupado_baja", 32'(oc_log[r+2+f]), 32'd0);
            end
        end
        comprobar("tramas", 32'(tramas[k]), 32'(n_esp));
    endtask

    task automatic correr(input int k, input int n);
        int f;
        int t0;
        f = (9 + ((PARS[k] != 0) ? 1 : 0) + STOPS[k]) * DIVS[k];
        vacio[k] = (fifo_q.size() == 0);
        tx_en[k] = 1'b1;
        t0 = cyc;
        repeat (n * (f + 3) + 10) paso();
        tx_en[k] = 1'b0;
        if (rd_q.size() > 0) comprobar("latencia_rd", 32'(rd_q[0]), 32'(t0 + 1));
        verificar(k, n, 1'b1);
    endtask

    initial begin
        bit         ok;
        int         n;
        int         r;
        logic [7:0] dec;

        rst      = 1'b0;
        tx_en    = '0;
        vacio    = '1;
        data_out = '0;

        // Directed: single byte, back-to-back bytes, parity variants, two stop bits
        reinicio(0); fifo_q.push_back(8'hA5); correr(0, 1);
        reinicio(0); fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03); correr(0, 3);
        reinicio(1); fifo_q.push_back(8'h07); correr(1, 1);
        reinicio(2); fifo_q.push_back(8'h07); correr(2, 1);
        reinicio(3); fifo_q.push_back(8'hFF); correr(3, 1);

        // Random bursts on every parameter set
        for (int k = 0; k < N_DUT; k++) begin
            reinicio(k);
            n = $urandom_range(2, 5);
            for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
            correr(k, n);
        end

        // tx_en dropped during the start bit
        reinicio(0);
        fifo_q.push_back(8'($urandom_range(0, 255)));
        fifo_q.push_back(8'($urandom_range(0, 255)));
        vacio[0] = 1'b0;
        tx_en[0] = 1'b1;
        esperar_rd(0, 20, ok);
        if (ok) begin
            paso();
            paso();
            tx_en[0] = 1'b0;
            repeat (160 + 40) paso();
            verificar(0, 1, 1'b0);
            comprobar("fifo_restante", 32'(fifo_q.size()), 32'd1);
        end

        // Reset during data bit 3 of 0x5A; the following byte must be the next one out
        reinicio(0);
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'h3C);
        vacio[0] = 1'b0;
        tx_en[0] = 1'b1;
        esperar_rd(0, 20, ok);
        if (ok) begin
            r = rd_q[0];
            while (cyc < r + 2 + 16 * 4 + 5) paso();
            rst = 1'b0;
            paso();
            comprobar("rst_medio_tx", 32'(tx[0]), 32'd1);
            comprobar("rst_medio_rd_en", 32'(rd_en[0]), 32'd0);
            comprobar("rst_medio_ocupado", 32'(ocupado[0]), 32'd0);
            comprobar("rst_medio_tramas", 32'(tramas[0]), 32'd0);
            rst = 1'b1;
            esperar_rd(1, 20, ok);
            if (ok) begin
                r = rd_q[1];
                repeat (170) paso();
                for (int j = 0; j < 8; j++) dec[j] = tx_log[r + 2 + (1 + j) * 16 + 8];
                $display("trama dut0 tras reset decodificada=%02h", dec);
                comprobar("byte_tras_rst", 32'(dec), 32'h3C);
                comprobar("tramas_tras_rst", 32'(tramas[0]), 32'd1);
                comprobar("n_rd_tras_rst", 32'(rd_q.size()), 32'd2);
            end
        end
        tx_en = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fallos);
        $finish;
    end

endmodule

// File: doc/serializador_uart.md
# serializador_uart

- Downstream consumer of the 8-bit synchronous FIFO.
- Drains the FIFO one byte at a time through its read port (`vacio`, `rd_en`, `data_out`).
- Transmits each byte as an asynchronous serial frame on `tx`: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO and the board pin.

## Interface

Parameters:
- `CLK_DIV`, 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `tx_en` in 1: permission to start new frames.
- `vacio` in 1: FIFO empty flag.
- `data_out` in 8: FIFO read data, valid the cycle after `rd_en`.
- `rd_en` out 1: FIFO read strobe, one-cycle pulse per byte.
- `tx` out 1: serial line, idle high.
- `ocupado` out 1: high from the `rd_en` cycle until the last stop-bit cycle, inclusive.
- `tramas` out 16: count of completed frames, wraps 0xFFFF→0x0000.

## Operation

- States: IDLE, LEER, CARGAR, START, DATOS, PARIDAD, STOP.
- IDLE → LEER when `tx_en`=1 and `vacio`=0, both sampled at the edge. Otherwise stay in IDLE.
- LEER: `rd_en`=1 for exactly this cycle. Always → CARGAR.
- CARGAR: latch `data_out` into the shift register. Compute the parity bit: XOR of the 8 bits, inverted for odd parity. → START.
- START: `tx`=0 for CLK_DIV cycles. → DATOS.
- DATOS: `tx`=shift[0] for CLK_DIV cycles per bit, then shift right. 8 bits, LSB first. → PARIDAD if PARITY≠0, else → STOP.
- PARIDAD: `tx`=parity bit for CLK_DIV cycles. → STOP.
- STOP: `tx`=1 for STOP_BITS×CLK_DIV cycles. On the last cycle, increment `tramas`. → IDLE.
- `tx` is registered and is 1 in IDLE, LEER and CARGAR.
- `rd_en` is registered and is never asserted outside LEER. It is therefore never asserted when `vacio` was 1 at the decision edge.
- `tx_en` falling mid-frame: the current frame completes; no new read is issued.
- `vacio` rising mid-frame: ignored until IDLE.
- `rst`=0 at any edge, including mid-frame:
  - next state is IDLE;
  - `tx`=1, `rd_en`=0, `ocupado`=0, `tramas`=0, all counters 0;
  - the in-flight byte is lost and not re-read.
- Arithmetic widths:
  - bit-time counter is $clog2(CLK_DIV) bits and counts 0..CLK_DIV-1;
  - data-bit counter is 3 bits;
  - stop counter counts to STOP_BITS.

## Timing

- Reset values: `tx`=1, `rd_en`=0, `ocupado`=0, `tramas`=0x0000, state IDLE.
- If `vacio`=0 and `tx_en`=1 at edge t, `rd_en` is high during cycle t+1.
- Start bit begins 2 cycles after the `rd_en` cycle.
- Frame bit-times: 1 + 8 + (PARITY≠0) + STOP_BITS, each CLK_DIV cycles.
- Defaults (CLK_DIV=16, no parity, 1 stop bit):
  - frame = 160 cycles;
  - `rd_en` period with the FIFO continuously non-empty = 1 + 1 + 160 + 1 = 163 cycles (LEER, CARGAR, frame, one IDLE cycle).
- `ocupado` drops in the IDLE cycle that follows STOP.
- `tramas` updates on the edge that leaves STOP.

## Structure

- Package `serializador_pkg`:
  - state enum `estado_t`;
  - parity constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - frame-length helper function.
- Sub-module `generador_baudios`:
  - CLK_DIV counter, cleared on every state change;
  - emits a one-cycle `fin_bit` tick on count CLK_DIV-1.
- Top-level contents: FSM, shift register, parity bit, stop counter, `tramas` counter.
- Bench connects through the existing FIFO interface (test clocking block drives `vacio`/`data_out` via the FIFO model).

## Test plan

- FIFO holds 0xA5, defaults:
  - one `rd_en` pulse;
  - `tx` = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each 16 cycles;
  - `tramas`=1.
- FIFO holds 0x01, 0x02, 0x03, `tx_en`=1 continuously:
  - three `rd_en` pulses exactly 163 cycles apart;
  - `tramas`=3;
  - no `rd_en` once `vacio`=1.
- PARITY=1, byte 0x07: parity bit = 1. PARITY=2, same byte: parity bit = 0.
- STOP_BITS=2, CLK_DIV=4, byte 0xFF: frame length = 44 cycles; `tx` high for 8 stop cycles.
- `rst`=0 during data bit 3 of 0x5A:
  - next cycle `tx`=1, `rd_en`=0, `ocupado`=0, `tramas`=0;
  - after release, the next FIFO byte is read, not 0x5A.
- `tx_en` dropped in START:
  - frame finishes normally;
  - no further `rd_en` while `tx_en`=0 even with `vacio`=0.
